// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - paces buffered stereo pairs into the DAC at a fixed tick rate; optional UNDERRUN_CNT_EN adds underrun_count
module dac_sample_scheduler #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int DIV         = 256
) (
  input  logic                       clk_12,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_left,
  input  logic [DATA_W-1:0]          in_right,
  input  logic                       flush,
  output logic [DATA_W-1:0]          dac_left,
  output logic [DATA_W-1:0]          dac_right,
  output logic                       dac_load,
  output logic                       running,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       underrun
`ifdef UNDERRUN_CNT_EN
  ,
  output logic [15:0]                underrun_count
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DVW = $clog2(DIV);

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t                  state;
  logic [DVW-1:0]          div_cnt;
  logic                    tick;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [2*DATA_W-1:0]     mem [DEPTH];
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;

  assign tick       = (div_cnt == DVW'(DIV - 1));
  assign fifo_empty = (fill_level == '0);
  // Full means not ready even if a pop lands in the same cycle.
  assign in_ready   = (fill_level < CW'(DEPTH));
  // A push in the flush cycle is dropped.
  assign push       = in_valid && in_ready && !flush;
  // Pops only happen on a RUN tick; flush takes priority over the pop.
  assign pop        = tick && (state == ST_RUN) && !fifo_empty && !flush;

  // Free-running sample-rate divider, cleared only by reset.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DVW'(1);
    end
  end

  // Sample storage; contents are meaningless once pointers are cleared.
  always_ff @(posedge clk_12) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fill_level <= fill_level + CW'(1);
      end else if (pop && !push) begin
        fill_level <= fill_level - CW'(1);
      end
    end
  end

  // Playback FSM with registered DAC outputs; every tick produces one load.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PRIME;
      running   <= 1'b0;
      dac_left  <= '0;
      dac_right <= '0;
      dac_load  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      dac_load <= tick;
      underrun <= 1'b0;
      if (flush) begin
        state     <= ST_PRIME;
        running   <= 1'b0;
        dac_left  <= '0;
        dac_right <= '0;
      end else if (tick) begin
        case (state)
          ST_PRIME: begin
            dac_left  <= '0;
            dac_right <= '0;
            if (fill_level >= CW'(PRIME_LEVEL)) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!fifo_empty) begin
              dac_left  <= mem[rd_ptr][2*DATA_W-1:DATA_W];
              dac_right <= mem[rd_ptr][DATA_W-1:0];
            end else begin
              dac_left  <= '0;
              dac_right <= '0;
              underrun  <= 1'b1;
              state     <= ST_PRIME;
              running   <= 1'b0;
            end
          end
          default: begin
            state   <= ST_PRIME;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef UNDERRUN_CNT_EN
  // Saturating count of underrun pulses; survives flush.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - directed self-checking bench for dac_sample_scheduler
module tb_dac_sample_scheduler;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int PL    = 4;
  localparam int DIV   = 16;

  logic          clk_12 = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_left = '0;
  logic [W-1:0]  in_right = '0;
  logic          flush = 1'b0;
  logic [W-1:0]  dac_left;
  logic [W-1:0]  dac_right;
  logic          dac_load;
  logic          running;
  logic [3:0]    fill_level;
  logic          underrun;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  dac_sample_scheduler #(.DATA_W(W), .DEPTH(DEPTH), .PRIME_LEVEL(PL), .DIV(DIV)) dut (
    .clk_12(clk_12), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .flush(flush),
    .dac_left(dac_left), .dac_right(dac_right), .dac_load(dac_load),
    .running(running), .fill_level(fill_level), .underrun(underrun)
`ifdef UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk_12 = ~clk_12;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All tasks start and end just after a falling edge.
  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    @(negedge clk_12);
    in_valid = 1'b0;
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk_12);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk_12);
    flush = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk_12);
      if (dac_load === 1'b1) begin seen = 1'b1; break; end
    end
    total_cnt++;
    if (!seen) $display("FAIL %s_load_timeout: got no dac_load, expected one within %0d cycles", tag, 2 * DIV);
    else pass_cnt++;
  endtask

  task automatic basic_sequence(input string tag);
    for (int k = 0; k < 4; k++) push_pair(W'(9 + k), W'(6 - k));
    total_cnt++; if (fill_level !== 4'd4) $display("FAIL %s_fill4: got %0d expected 4", tag, fill_level); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL %s_prime_running: got %0d expected 0", tag, running); else pass_cnt++;
    wait_load(tag);
    total_cnt++; if (dac_left !== 0 || dac_right !== 0) $display("FAIL %s_prime_data: got %0d/%0d expected 0/0", tag, dac_left, dac_right); else pass_cnt++;
    total_cnt++; if (running !== 1'b1) $display("FAIL %s_enter_run: got %0d expected 1", tag, running); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      wait_load(tag);
      total_cnt++;
      if (dac_left !== W'(9 + k) || dac_right !== W'(6 - k))
        $display("FAIL %s_pop%0d: got %0d/%0d expected %0d/%0d", tag, k, dac_left, dac_right, 9 + k, 6 - k);
      else pass_cnt++;
      skip(1);
      total_cnt++; if (dac_load !== 1'b0) $display("FAIL %s_load_width%0d: got %0d expected 0", tag, k, dac_load); else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    skip(3);
    total_cnt++;
    if (dac_left !== 0 || dac_right !== 0 || dac_load !== 0 || running !== 0 || underrun !== 0 || fill_level !== 0)
      $display("FAIL reset_values: got L=%0d R=%0d load=%0d run=%0d ur=%0d fill=%0d expected all 0",
               dac_left, dac_right, dac_load, running, underrun, fill_level);
    else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %0d expected 1", in_ready); else pass_cnt++;
    reset_n = 1'b1;
    basic_sequence("basic");
  endtask

  task automatic test_underrun();
    wait_load("underrun");
    total_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_pulse: got %0d expected 1", underrun); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL underrun_running: got %0d expected 0", running); else pass_cnt++;
    total_cnt++; if (dac_left !== 0 || dac_right !== 0) $display("FAIL underrun_data: got %0d/%0d expected 0/0", dac_left, dac_right); else pass_cnt++;
    skip(1);
    total_cnt++; if (underrun !== 1'b0) $display("FAIL underrun_width: got %0d expected 0", underrun); else pass_cnt++;
`ifdef UNDERRUN_CNT_EN
    total_cnt++; if (underrun_count !== 16'd1) $display("FAIL underrun_count: got %0d expected 1", underrun_count); else pass_cnt++;
`endif
    push_pair(16'd1, 16'd2);
    push_pair(16'd3, 16'd4);
    wait_load("reprime");
    total_cnt++; if (running !== 1'b0) $display("FAIL reprime_low: got %0d expected 0", running); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL reprime_no_underrun: got %0d expected 0", underrun); else pass_cnt++;
    push_pair(16'd5, 16'd6);
    push_pair(16'd7, 16'd8);
    wait_load("reprime");
    total_cnt++; if (running !== 1'b1) $display("FAIL reprime_high: got %0d expected 1", running); else pass_cnt++;
    total_cnt++; if (fill_level !== 4'd4) $display("FAIL reprime_fill: got %0d expected 4", fill_level); else pass_cnt++;
  endtask

  task automatic test_full();
    wait_load("full");
    do_flush();
    total_cnt++; if (fill_level !== 0 || running !== 0) $display("FAIL flush_clear: got fill=%0d run=%0d expected 0/0", fill_level, running); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) push_pair(W'(100 + i), W'(200 + i));
    total_cnt++; if (fill_level !== 4'd8) $display("FAIL full_fill: got %0d expected 8", fill_level); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %0d expected 0", in_ready); else pass_cnt++;
    push_pair(16'd999, 16'd999);
    total_cnt++; if (fill_level !== 4'd8) $display("FAIL full_reject: got %0d expected 8", fill_level); else pass_cnt++;
    wait_load("full");
    total_cnt++; if (running !== 1'b1 || dac_left !== 0) $display("FAIL full_prime: got run=%0d L=%0d expected 1/0", running, dac_left); else pass_cnt++;
    wait_load("full");
    total_cnt++; if (dac_left !== 16'd100 || dac_right !== 16'd200) $display("FAIL full_pop: got %0d/%0d expected 100/200", dac_left, dac_right); else pass_cnt++;
    total_cnt++; if (fill_level !== 4'd7 || in_ready !== 1'b1) $display("FAIL full_after_pop: got fill=%0d rdy=%0d expected 7/1", fill_level, in_ready); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      wait_load("wrap");
      total_cnt++;
      if (dac_left !== W'(101 + i) || dac_right !== W'(201 + i))
        $display("FAIL wrap_drain%0d: got %0d/%0d expected %0d/%0d", i, dac_left, dac_right, 101 + i, 201 + i);
      else pass_cnt++;
    end
    total_cnt++; if (fill_level !== 4'd3) $display("FAIL wrap_fill3: got %0d expected 3", fill_level); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      skip(DIV - 1);
      push_pair(W'(300 + k), W'(400 + k));
      total_cnt++;
      if (dac_load !== 1'b1 || dac_left !== W'(105 + k) || dac_right !== W'(205 + k))
        $display("FAIL wrap_pushpop%0d: got load=%0d %0d/%0d expected 1 %0d/%0d", k, dac_load, dac_left, dac_right, 105 + k, 205 + k);
      else pass_cnt++;
      total_cnt++; if (fill_level !== 4'd3) $display("FAIL wrap_pushpop_fill%0d: got %0d expected 3", k, fill_level); else pass_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      wait_load("wrap");
      total_cnt++;
      if (dac_left !== W'(300 + k) || dac_right !== W'(400 + k))
        $display("FAIL wrap_order%0d: got %0d/%0d expected %0d/%0d", k, dac_left, dac_right, 300 + k, 400 + k);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    wait_load("flush");
    do_flush();
    for (int i = 0; i < 5; i++) push_pair(W'(500 + i), W'(600 + i));
    wait_load("flush");
    total_cnt++; if (running !== 1'b1 || fill_level !== 4'd5) $display("FAIL flush_setup: got run=%0d fill=%0d expected 1/5", running, fill_level); else pass_cnt++;
    skip(DIV - 1);
    do_flush();
    total_cnt++;
    if (dac_load !== 1'b1 || dac_left !== 0 || dac_right !== 0)
      $display("FAIL flush_tick: got load=%0d %0d/%0d expected 1 0/0", dac_load, dac_left, dac_right);
    else pass_cnt++;
    total_cnt++; if (fill_level !== 0 || running !== 0) $display("FAIL flush_state: got fill=%0d run=%0d expected 0/0", fill_level, running); else pass_cnt++;
    skip(DIV - 1);
    total_cnt++; if (dac_load !== 1'b0) $display("FAIL flush_phase_early: got %0d expected 0", dac_load); else pass_cnt++;
    skip(1);
    total_cnt++; if (dac_load !== 1'b1) $display("FAIL flush_phase: got %0d expected 1", dac_load); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_pair(W'(50 + i), W'(60 + i));
    wait_load("midrst");
    wait_load("midrst");
    total_cnt++; if (dac_left !== 16'd50 || dac_right !== 16'd60) $display("FAIL midrst_pre: got %0d/%0d expected 50/60", dac_left, dac_right); else pass_cnt++;
    skip(2);
    @(posedge clk_12);
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (dac_left !== 0 || dac_right !== 0 || running !== 0 || fill_level !== 0 || dac_load !== 0 || underrun !== 0)
      $display("FAIL midrst_async: got L=%0d R=%0d run=%0d fill=%0d load=%0d ur=%0d expected all 0",
               dac_left, dac_right, running, fill_level, dac_load, underrun);
    else pass_cnt++;
    @(negedge clk_12);
    reset_n = 1'b1;
    basic_sequence("after_rst");
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
